// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen : registered fetch PC with valid/ready handshake, branch/trap
//          redirect and misaligned-target reporting.
// Revision: 1.0
// ============================================================================
module pc_gen #(
  parameter int unsigned       XLEN       = 64,
  parameter logic [63:0]       RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned       INST_BYTES = 4
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            if_ready_i,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            br_valid_i,
  input  logic            br_taken_i,
  input  logic            br_abs_i,
  input  logic [XLEN-1:0] br_base_i,
  input  logic [XLEN-1:0] br_offset_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            flush_o,
  output logic            br_misalign_o,
  output logic [XLEN-1:0] br_misalign_addr_o
);

  localparam int unsigned     ALIGN_BITS = $clog2(INST_BYTES);
  localparam logic [XLEN-1:0] RESET_PC_X = RESET_PC[XLEN-1:0];
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            br_take;
  logic            br_redirect;

  // jalr clears bit 0 of the register target; relative targets wrap mod 2^XLEN
  assign target      = br_abs_i ? {br_offset_i[XLEN-1:1], 1'b0}
                                : br_base_i + br_offset_i;
  assign misaligned  = |target[ALIGN_BITS-1:0];
  assign br_take     = br_valid_i & br_taken_i;
  assign br_redirect = br_take & ~misaligned;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC_X;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    flush_o    = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        flush_o = trap_valid_i | br_redirect;
        if (trap_valid_i) begin
          pc_d = trap_vec_i;
        end else if (br_redirect) begin
          pc_d = target;
        end else if (if_ready_i) begin
          pc_d = pc_q + PC_STEP;
        end
        // Misalign is reported even when a trap wins the PC this cycle
        if (br_take && misaligned) begin
          mis_d      = 1'b1;
          mis_addr_d = target;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pc_valid_o         = (state_q == RUN);
  assign pc_o               = pc_q;
  assign br_misalign_o      = mis_q;
  assign br_misalign_addr_o = mis_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// Directed bench for pc_gen: boot, stall, redirects, priority, misalign,
// wrap-around and asynchronous reset.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, rst_w;
  logic        if_ready, br_valid, br_taken, br_abs, trap_valid;
  logic [63:0] br_base, br_offset, trap_vec;

  logic        pc_valid, flush, mis;
  logic [63:0] pc, mis_addr;
  logic        pc_valid_w, flush_w, mis_w;
  logic [63:0] pc_w, mis_addr_w;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clock_i(clk), .reset_i(rst), .if_ready_i(if_ready),
    .pc_valid_o(pc_valid), .pc_o(pc),
    .br_valid_i(br_valid), .br_taken_i(br_taken), .br_abs_i(br_abs),
    .br_base_i(br_base), .br_offset_i(br_offset),
    .trap_valid_i(trap_valid), .trap_vec_i(trap_vec),
    .flush_o(flush), .br_misalign_o(mis), .br_misalign_addr_o(mis_addr)
  );

  pc_gen #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clock_i(clk), .reset_i(rst_w), .if_ready_i(if_ready),
    .pc_valid_o(pc_valid_w), .pc_o(pc_w),
    .br_valid_i(br_valid), .br_taken_i(br_taken), .br_abs_i(br_abs),
    .br_base_i(br_base), .br_offset_i(br_offset),
    .trap_valid_i(trap_valid), .trap_vec_i(trap_vec),
    .flush_o(flush_w), .br_misalign_o(mis_w), .br_misalign_addr_o(mis_addr_w)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    br_valid = 0; br_taken = 0; br_abs = 0; trap_valid = 0;
    br_base = '0; br_offset = '0; trap_vec = '0;
  endtask

  task automatic test_reset;
    rst = 1; rst_w = 1; if_ready = 0; clear_inputs();
    #3;
    tests++; if (pc_valid !== 1'b0) begin failed++; $display("FAIL rst_valid got=%b exp=0", pc_valid); end
    tests++; if (pc !== 64'h8000_0000) begin failed++; $display("FAIL rst_pc got=%h exp=80000000", pc); end
    tests++; if (mis !== 1'b0 || mis_addr !== 64'h0) begin failed++; $display("FAIL rst_mis got=%b/%h exp=0/0", mis, mis_addr); end
    tick();
    rst = 0;
    trap_valid = 1; trap_vec = 64'h1234_0000;
    #1;
    tests++; if (pc_valid !== 1'b0 || pc !== 64'h8000_0000) begin failed++; $display("FAIL boot_cycle0 got=%b/%h exp=0/80000000", pc_valid, pc); end
    tests++; if (flush !== 1'b0) begin failed++; $display("FAIL boot_flush got=%b exp=0", flush); end
    tick();
    clear_inputs();
    tests++; if (pc_valid !== 1'b1 || pc !== 64'h8000_0000) begin failed++; $display("FAIL boot_cycle1 got=%b/%h exp=1/80000000", pc_valid, pc); end
  endtask

  task automatic test_sequential;
    if_ready = 1;
    tick();
    tests++; if (pc !== 64'h8000_0004) begin failed++; $display("FAIL seq_4 got=%h exp=80000004", pc); end
    tick();
    if_ready = 0;
    tests++; if (pc !== 64'h8000_0008) begin failed++; $display("FAIL seq_8 got=%h exp=80000008", pc); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pc !== 64'h8000_0008 || flush !== 1'b0) begin failed++; $display("FAIL stall_%0d got=%h/%b exp=80000008/0", i, pc, flush); end
    end
    if_ready = 1;
    tick();
    if_ready = 0;
    tests++; if (pc !== 64'h8000_000C) begin failed++; $display("FAIL stall_release got=%h exp=8000000c", pc); end
  endtask

  task automatic test_branch_stall;
    br_valid = 1; br_taken = 0; br_base = 64'h8000_0000; br_offset = 64'h40;
    #1;
    tests++; if (flush !== 1'b0) begin failed++; $display("FAIL not_taken_flush got=%b exp=0", flush); end
    tick();
    tests++; if (pc !== 64'h8000_000C) begin failed++; $display("FAIL not_taken_pc got=%h exp=8000000c", pc); end
    br_taken = 1; br_offset = -64'sd16;
    #1;
    tests++; if (flush !== 1'b1) begin failed++; $display("FAIL br_flush got=%b exp=1", flush); end
    tick();
    clear_inputs();
    tests++; if (pc !== 64'h7FFF_FFF0 || pc_valid !== 1'b1) begin failed++; $display("FAIL br_pc got=%h/%b exp=7ffffff0/1", pc, pc_valid); end
  endtask

  task automatic test_priority;
    trap_valid = 1; trap_vec = 64'h8000_1000;
    br_valid = 1; br_taken = 1; br_base = 64'h8000_0000; br_offset = 64'h200;
    #1;
    tests++; if (flush !== 1'b1) begin failed++; $display("FAIL prio_flush got=%b exp=1", flush); end
    tick();
    clear_inputs();
    tests++; if (pc !== 64'h8000_1000) begin failed++; $display("FAIL prio_pc got=%h exp=80001000", pc); end
  endtask

  task automatic test_misalign;
    if_ready = 1; br_valid = 1; br_taken = 1; br_abs = 1; br_offset = 64'h8000_0103;
    #1;
    tests++; if (flush !== 1'b0) begin failed++; $display("FAIL mis_flush got=%b exp=0", flush); end
    tick();
    clear_inputs(); if_ready = 0;
    tests++; if (pc !== 64'h8000_1004) begin failed++; $display("FAIL mis_pc got=%h exp=80001004", pc); end
    tests++; if (mis !== 1'b1 || mis_addr !== 64'h8000_0102) begin failed++; $display("FAIL mis_pulse got=%b/%h exp=1/80000102", mis, mis_addr); end
    tick();
    tests++; if (mis !== 1'b0 || mis_addr !== 64'h8000_0102) begin failed++; $display("FAIL mis_end got=%b/%h exp=0/80000102", mis, mis_addr); end
    br_valid = 1; br_taken = 1; br_abs = 1; br_offset = 64'h8000_0105;
    #1;
    tests++; if (flush !== 1'b1) begin failed++; $display("FAIL jalr_flush got=%b exp=1", flush); end
    tick();
    clear_inputs();
    tests++; if (pc !== 64'h8000_0104 || mis !== 1'b0) begin failed++; $display("FAIL jalr_pc got=%h/%b exp=80000104/0", pc, mis); end
  endtask

  task automatic test_back_to_back;
    br_valid = 1; br_taken = 1; br_base = 64'h8000_0000; br_offset = 64'h2;
    tick();
    tests++; if (mis !== 1'b1 || mis_addr !== 64'h8000_0002) begin failed++; $display("FAIL b2b_first got=%b/%h exp=1/80000002", mis, mis_addr); end
    br_offset = 64'h6; trap_valid = 1; trap_vec = 64'h8000_2000;
    #1;
    tests++; if (flush !== 1'b1) begin failed++; $display("FAIL b2b_trap_flush got=%b exp=1", flush); end
    tick();
    clear_inputs();
    tests++; if (mis !== 1'b1 || mis_addr !== 64'h8000_0006 || pc !== 64'h8000_2000) begin failed++; $display("FAIL b2b_second got=%b/%h/%h exp=1/80000006/80002000", mis, mis_addr, pc); end
    tick();
    tests++; if (mis !== 1'b0 || mis_addr !== 64'h8000_0006) begin failed++; $display("FAIL b2b_end got=%b/%h exp=0/80000006", mis, mis_addr); end
  endtask

  task automatic test_async_reset;
    br_valid = 1; br_taken = 1; br_base = 64'h8000_0000; br_offset = 64'h400;
    #3;
    rst = 1;
    #1;
    tests++; if (pc_valid !== 1'b0 || pc !== 64'h8000_0000) begin failed++; $display("FAIL async_rst got=%b/%h exp=0/80000000", pc_valid, pc); end
    rst = 0;
    tick();
    clear_inputs();
    tests++; if (pc_valid !== 1'b1 || pc !== 64'h8000_0000) begin failed++; $display("FAIL async_rst_lost got=%b/%h exp=1/80000000", pc_valid, pc); end
  endtask

  task automatic test_wrap;
    clear_inputs(); if_ready = 1;
    tick();
    rst_w = 0;
    #1;
    tests++; if (pc_valid_w !== 1'b0 || pc_w !== 64'hFFFF_FFFF_FFFF_FFFC) begin failed++; $display("FAIL wrap_boot got=%b/%h exp=0/fffffffffffffffc", pc_valid_w, pc_w); end
    tick();
    tests++; if (pc_valid_w !== 1'b1 || pc_w !== 64'hFFFF_FFFF_FFFF_FFFC) begin failed++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffffffffffc", pc_valid_w, pc_w); end
    tick();
    tests++; if (pc_w !== 64'h0) begin failed++; $display("FAIL wrap_zero got=%h exp=0", pc_w); end
    tick();
    tests++; if (pc_w !== 64'h4) begin failed++; $display("FAIL wrap_four got=%h exp=4", pc_w); end
    #3;
    rst_w = 1;
    #1;
    tests++; if (pc_valid_w !== 1'b0 || pc_w !== 64'hFFFF_FFFF_FFFF_FFFC) begin failed++; $display("FAIL wrap_async got=%b/%h exp=0/fffffffffffffffc", pc_valid_w, pc_w); end
    if_ready = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_priority();
    test_misalign();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
